serdesphy_link_seq: RTL and testbench

- Parametrised multi-lane link bring-up sequencer for the SerDes PHY, in the clk_ref_24m domain.
- Sits between the CSR/POR logic and the per-lane PMA controls.
- Sequences shared-PLL enable, per-lane TX/RX enable and CDR reset release, then waits for lock and alignment.
- Declares phy_ready, supervises lock loss, and retries bounded times before flagging link failure.

---
 rtl/serdesphy_pkg.sv | 42 ++++
 rtl/serdesphy_lock_filter.sv | 47 ++++
 rtl/serdesphy_link_seq.sv | 249 ++++++++++++++++++++++++
 tb/tb_serdesphy_link_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// rtl/serdesphy_pkg.sv - shared state encoding, defaults and helpers for the SerDes PHY link sequencer
//
// Purpose: common definitions imported by serdesphy_link_seq and serdesphy_lock_filter.
// Contents: FSM state encodings and enum, default lock timeouts, retry counter width,
//           and a lane-mask coverage helper.

package serdesphy_pkg;

  localparam logic [2:0] ENC_IDLE       = 3'd0;
  localparam logic [2:0] ENC_PLL_START  = 3'd1;
  localparam logic [2:0] ENC_PLL_WAIT   = 3'd2;
  localparam logic [2:0] ENC_TX_ON      = 3'd3;
  localparam logic [2:0] ENC_CDR_WAIT   = 3'd4;
  localparam logic [2:0] ENC_ALIGN_WAIT = 3'd5;
  localparam logic [2:0] ENC_READY      = 3'd6;
  localparam logic [2:0] ENC_FAIL       = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE       = ENC_IDLE,
    ST_PLL_START  = ENC_PLL_START,
    ST_PLL_WAIT   = ENC_PLL_WAIT,
    ST_TX_ON      = ENC_TX_ON,
    ST_CDR_WAIT   = ENC_CDR_WAIT,
    ST_ALIGN_WAIT = ENC_ALIGN_WAIT,
    ST_READY      = ENC_READY,
    ST_FAIL       = ENC_FAIL
  } state_e;

  // 1 ms and 200 us at 24 MHz
  localparam int PLL_LOCK_TMO_DEF = 24000;
  localparam int CDR_LOCK_TMO_DEF = 4800;

  localparam int RETRY_W   = 4;
  localparam int MAX_LANES = 8;

  // True when every lane set in mask is also set in bits.
  function automatic logic lanes_cover(input logic [MAX_LANES-1:0] bits,
                                       input logic [MAX_LANES-1:0] mask);
    return (bits & mask) == mask;
  endfunction

endpackage

// File: rtl/serdesphy_lock_filter.sv
// rtl/serdesphy_lock_filter.sv - consecutive-cycle debounce counter for a raw lock indication
//
// Purpose: reports lock only after lock_i has been high for LOCK_FILT consecutive cycles.
// Ports:
//   clk_i     in   clock
//   rst_n_i   in   asynchronous active-low reset
//   clear_i   in   synchronous clear of the run counter
//   lock_i    in   raw lock
//   locked_o  out  filtered lock (run counter has reached LOCK_FILT)

module serdesphy_lock_filter
  import serdesphy_pkg::*;
#(
  parameter int LOCK_FILT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic lock_i,
  output logic locked_o
);

  localparam int CW = $clog2(LOCK_FILT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any low cycle restarts the run; the count parks at LOCK_FILT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !lock_i) begin
      cnt_d = '0;
    end else if (cnt_q != CW'(LOCK_FILT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign locked_o = (cnt_q == CW'(LOCK_FILT));

endmodule

// File: rtl/serdesphy_link_seq.sv
// rtl/serdesphy_link_seq.sv - multi-lane SerDes PHY link bring-up sequencer
//
// Purpose: sequences shared PLL enable, per-lane TX/RX enable and CDR reset release,
//          waits for PLL lock, CDR lock and word alignment, declares phy_ready, supervises
//          lock loss and retries a bounded number of times before flagging link_fail.
// Optional feature: define SERDESPHY_LANE_DEGRADE_EN to let a CDR/alignment timeout drop
//          the failing lanes and bring the link up on the surviving subset (degraded).
// Ports (clk_ref_24m domain):
//   clk_ref_24m   in   reference clock
//   rst_n         in   asynchronous active-low reset
//   power_good    in   POR complete and supplies good
//   phy_en        in   CSR PHY enable
//   lane_en_mask  in   requested lanes, sampled when leaving IDLE
//   pll_lock      in   raw shared PLL lock
//   cdr_lock      in   per-lane CDR lock
//   rx_aligned    in   per-lane word alignment done
//   pll_enable    out  shared PLL enable
//   tx_en         out  per-lane serializer enable
//   rx_en         out  per-lane deserializer enable
//   cdr_rst       out  per-lane CDR reset, active high
//   lanes_up      out  lanes in service
//   phy_ready     out  link up
//   degraded      out  link up on a lane subset
//   link_fail     out  retry budget exhausted
//   retry_cnt     out  retries since last IDLE
//   state         out  FSM state encoding

module serdesphy_link_seq
  import serdesphy_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int TMR_W        = 16,
  parameter int PLL_LOCK_TMO = PLL_LOCK_TMO_DEF,
  parameter int CDR_LOCK_TMO = CDR_LOCK_TMO_DEF,
  parameter int LOCK_FILT    = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 clk_ref_24m,
  input  logic                 rst_n,
  input  logic                 power_good,
  input  logic                 phy_en,
  input  logic [NUM_LANES-1:0] lane_en_mask,
  input  logic                 pll_lock,
  input  logic [NUM_LANES-1:0] cdr_lock,
  input  logic [NUM_LANES-1:0] rx_aligned,
  output logic                 pll_enable,
  output logic [NUM_LANES-1:0] tx_en,
  output logic [NUM_LANES-1:0] rx_en,
  output logic [NUM_LANES-1:0] cdr_rst,
  output logic [NUM_LANES-1:0] lanes_up,
  output logic                 phy_ready,
  output logic                 degraded,
  output logic                 link_fail,
  output logic [RETRY_W-1:0]   retry_cnt,
  output logic [2:0]           state
);

  state_e               state_q;
  logic [NUM_LANES-1:0] active_q;
  logic [NUM_LANES-1:0] tx_en_q, rx_en_q, cdr_rst_q, lanes_up_q;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q;
  logic                 pll_enable_q, phy_ready_q, degraded_q, link_fail_q;
  // Remembers that lanes were dropped on the way up; only shown on degraded once READY.
  logic                 deg_flag_q;

  logic pll_locked, filt_clear;
  logic cdr_all, align_all;
  logic pll_tmo, cdr_tmo;
  logic degrade_ok, retry_req;

  // The filter only runs inside PLL_WAIT, so every attempt starts from a fresh count.
  assign filt_clear = (state_q != ST_PLL_WAIT);

  serdesphy_lock_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_pll_filt (
    .clk_i    (clk_ref_24m),
    .rst_n_i  (rst_n),
    .clear_i  (filt_clear),
    .lock_i   (pll_lock),
    .locked_o (pll_locked)
  );

  assign timer_d   = (&timer_q) ? timer_q : timer_q + 1'b1;
  assign pll_tmo   = (timer_q == TMR_W'(PLL_LOCK_TMO));
  assign cdr_tmo   = (timer_q == TMR_W'(CDR_LOCK_TMO));
  assign cdr_all   = lanes_cover(MAX_LANES'(cdr_lock), MAX_LANES'(active_q));
  assign align_all = lanes_cover(MAX_LANES'(rx_aligned), MAX_LANES'(active_q));

`ifdef SERDESPHY_LANE_DEGRADE_EN
  // Lanes that are still healthy at a CDR/alignment timeout.
  logic [NUM_LANES-1:0] good;
  assign good = (state_q == ST_ALIGN_WAIT) ? (active_q & cdr_lock & rx_aligned)
                                           : (active_q & cdr_lock);
  assign degrade_ok = |good;
`else
  assign degrade_ok = 1'b0;
`endif

  // Conditions that restart bring-up (or end in FAIL when the budget is spent).
  // A lock seen in the same cycle as the timeout takes precedence.
  always_comb begin
    retry_req = 1'b0;
    case (state_q)
      ST_PLL_WAIT:   retry_req = !pll_locked && pll_tmo;
      ST_CDR_WAIT:   retry_req = !cdr_all && cdr_tmo && !degrade_ok;
      ST_ALIGN_WAIT: retry_req = !align_all && cdr_tmo && !degrade_ok;
      ST_READY:      retry_req = !cdr_all || !pll_lock;
      default:       retry_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      active_q     <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      pll_enable_q <= 1'b0;
      tx_en_q      <= '0;
      rx_en_q      <= '0;
      cdr_rst_q    <= '1;
      lanes_up_q   <= '0;
      phy_ready_q  <= 1'b0;
      degraded_q   <= 1'b0;
      deg_flag_q   <= 1'b0;
      link_fail_q  <= 1'b0;
    end else if (!power_good || !phy_en) begin
      state_q      <= ST_IDLE;
      active_q     <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      pll_enable_q <= 1'b0;
      tx_en_q      <= '0;
      rx_en_q      <= '0;
      cdr_rst_q    <= '1;
      lanes_up_q   <= '0;
      phy_ready_q  <= 1'b0;
      degraded_q   <= 1'b0;
      deg_flag_q   <= 1'b0;
      link_fail_q  <= 1'b0;
    end else if (retry_req) begin
      // Tear the lanes and PLL down on the transition so every attempt starts cold.
      pll_enable_q <= 1'b0;
      tx_en_q      <= '0;
      rx_en_q      <= '0;
      cdr_rst_q    <= '1;
      lanes_up_q   <= '0;
      phy_ready_q  <= 1'b0;
      degraded_q   <= 1'b0;
      if (retry_q == RETRY_W'(MAX_RETRY)) begin
        state_q     <= ST_FAIL;
        link_fail_q <= 1'b1;
      end else begin
        retry_q    <= retry_q + 1'b1;
        deg_flag_q <= 1'b0;
        state_q    <= ST_PLL_START;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|lane_en_mask) begin
            active_q   <= lane_en_mask;
            deg_flag_q <= 1'b0;
            state_q    <= ST_PLL_START;
          end
        end
        ST_PLL_START: begin
          pll_enable_q <= 1'b1;
          timer_q      <= '0;
          state_q      <= ST_PLL_WAIT;
        end
        ST_PLL_WAIT: begin
          timer_q <= timer_d;
          if (pll_locked) begin
            state_q <= ST_TX_ON;
          end
        end
        ST_TX_ON: begin
          tx_en_q   <= active_q;
          rx_en_q   <= active_q;
          cdr_rst_q <= ~active_q;
          timer_q   <= '0;
          state_q   <= ST_CDR_WAIT;
        end
        ST_CDR_WAIT: begin
          if (cdr_all) begin
            timer_q <= '0;
            state_q <= ST_ALIGN_WAIT;
          end
`ifdef SERDESPHY_LANE_DEGRADE_EN
          else if (cdr_tmo) begin
            // retry_req already covered good == 0, so some lane survives here.
            active_q   <= good;
            tx_en_q    <= good;
            rx_en_q    <= good;
            cdr_rst_q  <= ~good;
            deg_flag_q <= 1'b1;
            timer_q    <= '0;
            state_q    <= ST_ALIGN_WAIT;
          end
`endif
          else begin
            timer_q <= timer_d;
          end
        end
        ST_ALIGN_WAIT: begin
          if (align_all) begin
            phy_ready_q <= 1'b1;
            lanes_up_q  <= active_q;
            degraded_q  <= deg_flag_q;
            state_q     <= ST_READY;
          end
`ifdef SERDESPHY_LANE_DEGRADE_EN
          else if (cdr_tmo) begin
            active_q    <= good;
            tx_en_q     <= good;
            rx_en_q     <= good;
            cdr_rst_q   <= ~good;
            deg_flag_q  <= 1'b1;
            phy_ready_q <= 1'b1;
            lanes_up_q  <= good;
            degraded_q  <= 1'b1;
            state_q     <= ST_READY;
          end
`endif
          else begin
            timer_q <= timer_d;
          end
        end
        // READY is supervised through retry_req; FAIL leaves only via the override.
        default: ;
      endcase
    end
  end

  assign pll_enable = pll_enable_q;
  assign tx_en      = tx_en_q;
  assign rx_en      = rx_en_q;
  assign cdr_rst    = cdr_rst_q;
  assign lanes_up   = lanes_up_q;
  assign phy_ready  = phy_ready_q;
  assign degraded   = degraded_q;
  assign link_fail  = link_fail_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_serdesphy_link_seq.sv
// tb/tb_serdesphy_link_seq.sv - directed scoreboard bench for serdesphy_link_seq

module tb_serdesphy_link_seq;

  logic       clk_ref_24m;
  logic       rst_n;
  logic       power_good;
  logic       phy_en;
  logic [3:0] lane_en_mask;
  logic       pll_lock;
  logic [3:0] cdr_lock;
  logic [3:0] rx_aligned;
  logic       pll_enable;
  logic [3:0] tx_en;
  logic [3:0] rx_en;
  logic [3:0] cdr_rst;
  logic [3:0] lanes_up;
  logic       phy_ready;
  logic       degraded;
  logic       link_fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_s;
  logic [2:0] prev_state = 3'd0;
  bit         mon_en = 1'b0;

  serdesphy_link_seq #(
    .NUM_LANES    (4),
    .TMR_W        (16),
    .PLL_LOCK_TMO (64),
    .CDR_LOCK_TMO (32),
    .LOCK_FILT    (4),
    .MAX_RETRY    (2)
  ) dut (
    .clk_ref_24m  (clk_ref_24m),
    .rst_n        (rst_n),
    .power_good   (power_good),
    .phy_en       (phy_en),
    .lane_en_mask (lane_en_mask),
    .pll_lock     (pll_lock),
    .cdr_lock     (cdr_lock),
    .rx_aligned   (rx_aligned),
    .pll_enable   (pll_enable),
    .tx_en        (tx_en),
    .rx_en        (rx_en),
    .cdr_rst      (cdr_rst),
    .lanes_up     (lanes_up),
    .phy_ready    (phy_ready),
    .degraded     (degraded),
    .link_fail    (link_fail),
    .retry_cnt    (retry_cnt),
    .state        (state)
  );

  initial clk_ref_24m = 1'b0;
  always #5 clk_ref_24m = ~clk_ref_24m;

  // Every observed state change must match the next expected state in the scoreboard.
  always @(negedge clk_ref_24m) begin
    if (mon_en && state !== prev_state) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL state_seq_extra observed=%0d expected=none", state);
      end
      if (exp_q.size() != 0) begin
        exp_s = exp_q.pop_front();
        checks++;
        assert (state === exp_s) else begin
          errors++;
          $error("FAIL state_seq observed=%0d expected=%0d", state, exp_s);
        end
      end
    end
    prev_state = state;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk_ref_24m);
      n++;
    end
    checks++;
    assert (state === s) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, state, s);
    end
  endtask

  task automatic push(input logic [2:0] s);
    exp_q.push_back(s);
  endtask

  task automatic push_bringup();
    for (int i = 1; i <= 6; i++) exp_q.push_back(3'(i));
  endtask

  initial begin
    int n;
    rst_n = 1'b1; power_good = 1'b0; phy_en = 1'b0; lane_en_mask = 4'h0;
    pll_lock = 1'b0; cdr_lock = 4'h0; rx_aligned = 4'h0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cdr_rst", 32'(cdr_rst), 32'hf);
    chk("rst_pll_enable", 32'(pll_enable), 32'd0);
    chk("rst_tx_en", 32'(tx_en), 32'd0);
    chk("rst_phy_ready", 32'(phy_ready), 32'd0);
    chk("rst_link_fail", 32'(link_fail), 32'd0);
    chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
    mon_en = 1'b1;

    // Nominal bring-up on all four lanes
    @(negedge clk_ref_24m);
    rst_n = 1'b1; power_good = 1'b1; phy_en = 1'b1; lane_en_mask = 4'hf;
    push_bringup();
    wait_state(3'd2, 4, "nom_pll_wait");
    pll_lock = 1'b1;
    wait_state(3'd3, 12, "nom_tx_on");
    cdr_lock = 4'hf;
    wait_state(3'd5, 10, "nom_align_wait");
    rx_aligned = 4'hf;
    wait_state(3'd6, 10, "nom_ready");
    chk("nom_phy_ready", 32'(phy_ready), 32'd1);
    chk("nom_lanes_up", 32'(lanes_up), 32'hf);
    chk("nom_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("nom_tx_en", 32'(tx_en), 32'hf);
    chk("nom_rx_en", 32'(rx_en), 32'hf);
    chk("nom_cdr_rst", 32'(cdr_rst), 32'h0);
    chk("nom_pll_enable", 32'(pll_enable), 32'd1);
    chk("nom_degraded", 32'(degraded), 32'd0);

    // CDR lock loss on lane 2 in READY
    push_bringup();
    cdr_lock = 4'b1011;
    @(negedge clk_ref_24m);
    chk("loss_state", 32'(state), 32'd1);
    chk("loss_phy_ready", 32'(phy_ready), 32'd0);
    chk("loss_retry_cnt", 32'(retry_cnt), 32'd1);
    chk("loss_cdr_rst", 32'(cdr_rst), 32'hf);
    chk("loss_tx_en", 32'(tx_en), 32'h0);
    cdr_lock = 4'hf;
    wait_state(3'd6, 40, "relock_ready");
    chk("relock_phy_ready", 32'(phy_ready), 32'd1);
    chk("relock_retry_cnt", 32'(retry_cnt), 32'd1);

    // PLL lock loss in READY, then phy_en drop back to IDLE
    push(3'd1);
    pll_lock = 1'b0;
    @(negedge clk_ref_24m);
    chk("pll_loss_state", 32'(state), 32'd1);
    chk("pll_loss_retry_cnt", 32'(retry_cnt), 32'd2);
    chk("pll_loss_pll_enable", 32'(pll_enable), 32'd0);
    push(3'd0);
    phy_en = 1'b0;
    @(negedge clk_ref_24m);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_retry_cnt", 32'(retry_cnt), 32'd0);

    // PLL never locks: three timeouts end in FAIL
    cdr_lock = 4'h0; rx_aligned = 4'h0;
    push(3'd1); push(3'd2); push(3'd1); push(3'd2); push(3'd1); push(3'd2); push(3'd7);
    phy_en = 1'b1;
    wait_state(3'd2, 4, "nolock_pll_wait");
    pll_lock = 1'b1;
    repeat (3) @(negedge clk_ref_24m);
    pll_lock = 1'b0;
    @(negedge clk_ref_24m);
    chk("short_lock_pulse_state", 32'(state), 32'd2);
    wait_state(3'd1, 100, "nolock_retry1");
    chk("nolock_retry1_cnt", 32'(retry_cnt), 32'd1);
    chk("nolock_retry1_pll_enable", 32'(pll_enable), 32'd0);
    wait_state(3'd2, 4, "nolock_pll_wait2");
    n = 0;
    while (state === 3'd2 && n < 200) begin
      @(negedge clk_ref_24m);
      n++;
    end
    chk("pll_wait_duration_in_range", 32'(n >= 63 && n <= 67), 32'd1);
    chk("nolock_retry2_cnt", 32'(retry_cnt), 32'd2);
    wait_state(3'd7, 100, "nolock_fail");
    chk("fail_link_fail", 32'(link_fail), 32'd1);
    chk("fail_pll_enable", 32'(pll_enable), 32'd0);
    chk("fail_cdr_rst", 32'(cdr_rst), 32'hf);
    repeat (5) @(negedge clk_ref_24m);
    chk("fail_sticky_state", 32'(state), 32'd7);
    push(3'd0);
    phy_en = 1'b0;
    @(negedge clk_ref_24m);
    chk("fail_exit_state", 32'(state), 32'd0);
    chk("fail_exit_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("fail_exit_link_fail", 32'(link_fail), 32'd0);

    // Partial lane mask 0101
    lane_en_mask = 4'b0101; pll_lock = 1'b1; cdr_lock = 4'b0101; rx_aligned = 4'b0101;
    push_bringup();
    phy_en = 1'b1;
    wait_state(3'd6, 40, "partial_ready");
    chk("partial_tx_en", 32'(tx_en), 32'h5);
    chk("partial_rx_en", 32'(rx_en), 32'h5);
    chk("partial_cdr_rst", 32'(cdr_rst), 32'ha);
    chk("partial_lanes_up", 32'(lanes_up), 32'h5);
    lane_en_mask = 4'hf; cdr_lock = 4'b0111;
    repeat (3) @(negedge clk_ref_24m);
    chk("mask_change_ignored_state", 32'(state), 32'd6);
    chk("mask_change_ignored_lanes", 32'(lanes_up), 32'h5);
    push(3'd0);
    phy_en = 1'b0;
    @(negedge clk_ref_24m);
    chk("partial_idle_state", 32'(state), 32'd0);

    // CDR timeout with lane 2 never locking
    cdr_lock = 4'b1011; rx_aligned = 4'h0;
    push(3'd1); push(3'd2); push(3'd3); push(3'd4);
`ifdef SERDESPHY_LANE_DEGRADE_EN
    push(3'd5);
    phy_en = 1'b1;
    wait_state(3'd5, 80, "degrade_align_wait");
    chk("degrade_tx_en", 32'(tx_en), 32'hb);
    chk("degrade_cdr_rst", 32'(cdr_rst), 32'h4);
    push(3'd6);
    rx_aligned = 4'b1011;
    wait_state(3'd6, 8, "degrade_ready");
    chk("degrade_flag", 32'(degraded), 32'd1);
    chk("degrade_lanes_up", 32'(lanes_up), 32'hb);
    chk("degrade_phy_ready", 32'(phy_ready), 32'd1);
`else
    push(3'd1);
    phy_en = 1'b1;
    wait_state(3'd4, 20, "cdr_tmo_cdr_wait");
    wait_state(3'd1, 60, "cdr_tmo_retry");
    chk("cdr_tmo_retry_cnt", 32'(retry_cnt), 32'd1);
    chk("cdr_tmo_tx_en", 32'(tx_en), 32'h0);
    chk("cdr_tmo_cdr_rst", 32'(cdr_rst), 32'hf);
    chk("cdr_tmo_degraded", 32'(degraded), 32'd0);
`endif
    push(3'd0);
    phy_en = 1'b0;
    @(negedge clk_ref_24m);
    chk("degrade_exit_state", 32'(state), 32'd0);
    chk("degrade_exit_flag", 32'(degraded), 32'd0);

    // Asynchronous reset in the middle of CDR_WAIT
    cdr_lock = 4'h0; rx_aligned = 4'h0;
    push(3'd1); push(3'd2); push(3'd3); push(3'd4);
    phy_en = 1'b1;
    wait_state(3'd4, 20, "areset_cdr_wait");
    #2;
    push(3'd0);
    rst_n = 1'b0;
    #1;
    chk("areset_state", 32'(state), 32'd0);
    chk("areset_cdr_rst", 32'(cdr_rst), 32'hf);
    chk("areset_tx_en", 32'(tx_en), 32'h0);
    chk("areset_pll_enable", 32'(pll_enable), 32'd0);
    @(negedge clk_ref_24m);
    rst_n = 1'b1; cdr_lock = 4'hf; rx_aligned = 4'hf;
    push_bringup();
    wait_state(3'd6, 40, "areset_rebringup");

    // power_good drop in READY
    push(3'd0);
    power_good = 1'b0;
    @(negedge clk_ref_24m);
    chk("pg_drop_state", 32'(state), 32'd0);
    chk("pg_drop_cdr_rst", 32'(cdr_rst), 32'hf);
    chk("pg_drop_phy_ready", 32'(phy_ready), 32'd0);
    chk("pg_drop_lanes_up", 32'(lanes_up), 32'h0);
    chk("pg_drop_tx_en", 32'(tx_en), 32'h0);

    @(negedge clk_ref_24m);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
